encoder32x5_rr: RTL



---
 rtl/encoder_pkg.sv | 23 ++
 rtl/ffs32_rot.sv | 30 +++
 rtl/encoder32x5_rr.sv | 97 +++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared types and widths for the 32-to-5 request encoder.
package encoder_pkg;

    localparam int unsigned N_LINES = 32;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned CNT_W   = IDX_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } enc_state_t;

    // Number of set bits in a request vector; result range 0..N_LINES.
    function automatic logic [CNT_W-1:0] popcount32(input logic [N_LINES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(N_LINES); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/ffs32_rot.sv
// Combinational find-first-set over 32 bits, searching upward from a rotation
// offset with wrap; offset 0 degenerates to lowest-index-wins.
module ffs32_rot
    import encoder_pkg::*;
(
    input  logic [N_LINES-1:0] vec_i,
    input  logic [IDX_W-1:0]   off_i,
    output logic               found_c,
    output logic [IDX_W-1:0]   idx_c
);

    logic [2*N_LINES-1:0] dbl;
    logic [N_LINES-1:0]   rot;
    logic [IDX_W-1:0]     pos;

    // Rotate so the offset lands at bit 0, then take the lowest set bit.
    always_comb begin
        dbl = {vec_i, vec_i};
        rot = N_LINES'(dbl >> off_i);
        pos = '0;
        for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = IDX_W'(i);
            end
        end
        found_c = |vec_i;
        idx_c   = off_i + pos;
    end

endmodule

// File: rtl/encoder32x5_rr.sv
// Sequential 32-to-5 request encoder: sticky pending set, one index per
// valid/ready handshake. Define ENCODER_RR_EN for round-robin, else fixed priority.
module encoder32x5_rr
    import encoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N_LINES-1:0] req_n,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [IDX_W-1:0]   idx,
    output logic [CNT_W-1:0]   pend_cnt
);

    enc_state_t         state_q, state_d;
    logic [N_LINES-1:0] p_q, p_d;
    logic [N_LINES-1:0] clr;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   search_off;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               load;

`ifdef ENCODER_RR_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = sel_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign search_off = ptr_q;
`else
    assign search_off = '0;
`endif

    ffs32_rot u_ffs (
        .vec_i   (p_q),
        .off_i   (search_off),
        .found_c (sel_found),
        .idx_c   (sel_idx)
    );

    // Selection works on the pre-capture pending set; a fresh capture wins over a clear.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        clr     = '0;
        load    = en && sel_found && ((state_q == IDLE) || out_ready);
        if (load) begin
            state_d = VALID;
            valid_d = 1'b1;
            idx_d   = sel_idx;
            clr     = N_LINES'(1) << sel_idx;
        end else if ((state_q == VALID) && out_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
        p_d   = (p_q & ~clr) | (en ? ~req_n : '0);
        cnt_d = popcount32(p_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign idx       = idx_q;
    assign pend_cnt  = cnt_q;

endmodule
